// File: rtl/data_path.sv
// data_path: single-bus register-transfer datapath for the phase-1 RISC CPU.
// Sixteen GPRs, HI/LO, PC, MDR, Y and a 64-bit Z share one 32-bit bus.
// Every register has its own external load strobe. The ALU sits between
// Y (operand A) and the bus (operand B) and feeds Z.
module data_path (
   input  logic        clock,
   input  logic        clear,
   input  logic [15:0] regIn,
   input  logic        HiIn,
   input  logic        LoIn,
   input  logic        ZIn,
   input  logic        PCIn,
   input  logic        MDRIn,
   input  logic        YIn,
   input  logic [15:0] regOut,
   input  logic        HiOut,
   input  logic        LoOut,
   input  logic        ZHiOut,
   input  logic        ZLoOut,
   input  logic        PCOut,
   input  logic        MDROut,
   input  logic [31:0] Mdata,
   input  logic        MDRread,
   input  logic [4:0]  ALUcode,
   input  logic [31:0] temp,
   input  logic        tempEnable,
   output logic [31:0] BusMuxOut
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_ROR  = 5'b00111,
      OP_ROL  = 5'b01000,
      OP_SHR  = 5'b01001,
      OP_SHRA = 5'b01010,
      OP_SHL  = 5'b01011,
      OP_DIV  = 5'b01111,
      OP_MUL  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } alu_op_e;

   logic [15:0][31:0] gpr;
   logic [31:0] hi, lo, pc, mdr, y;
   logic [63:0] z;
   logic [31:0] bus;
   logic [63:0] alu;

   // Bus mux: sources are applied lowest priority first so the last match wins,
   // giving temp > R0 > ... > R15 > HI > LO > ZHi > ZLo > PC > MDR.
   always_comb begin
      bus = '0;
      if (MDROut) bus = mdr;
      if (PCOut)  bus = pc;
      if (ZLoOut) bus = z[31:0];
      if (ZHiOut) bus = z[63:32];
      if (LoOut)  bus = lo;
      if (HiOut)  bus = hi;
      for (int i = 15; i >= 0; i--)
         if (regOut[i]) bus = gpr[i];
      if (tempEnable) bus = temp;
   end

   assign BusMuxOut = bus;

   // ALU helpers. The divisor is forced non-zero so the divider never sees 0;
   // the divide-by-zero result is substituted below.
   logic [4:0]         sh;
   logic [31:0]        dvs;
   logic signed [31:0] quo, rem;
   logic [63:0]        prod, dbl, ror_w, rol_w;
   logic [31:0]        sra_w;

   assign sh    = bus[4:0];
   assign dvs   = (bus == 32'd0) ? 32'd1 : bus;
   assign quo   = $signed(y) / $signed(dvs);
   assign rem   = $signed(y) % $signed(dvs);
   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign prod  = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
   assign dbl   = {y, y};
   assign ror_w = dbl >> sh;
   assign rol_w = dbl << sh;
   assign sra_w = $signed(y) >>> sh;

   // ALU result select; single-word results are zero-extended into the high half.
   always_comb begin
      alu = '0;
      case (ALUcode)
         OP_ADD:  alu = {32'd0, y + bus};
         OP_SUB:  alu = {32'd0, y - bus};
         OP_AND:  alu = {32'd0, y & bus};
         OP_OR:   alu = {32'd0, y | bus};
         OP_ROR:  alu = {32'd0, ror_w[31:0]};
         OP_ROL:  alu = {32'd0, rol_w[63:32]};
         OP_SHR:  alu = {32'd0, y >> sh};
         OP_SHRA: alu = {32'd0, sra_w};
         OP_SHL:  alu = {32'd0, y << sh};
         OP_DIV:  alu = (bus == 32'd0) ? {y, 32'hFFFF_FFFF} : {rem, quo};
         OP_MUL:  alu = prod;
         OP_NEG:  alu = {32'd0, 32'd0 - bus};
         OP_NOT:  alu = {32'd0, ~bus};
         default: alu = '0;
      endcase
   end

   // General-purpose register file; clear overrides every load strobe.
   always_ff @(posedge clock) begin
      if (!clear) begin
         gpr <= '0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (regIn[i]) gpr[i] <= bus;
      end
   end

   // Special registers: HI, LO, PC, Y and MDR from the bus (MDR optionally from memory), Z from the ALU.
   always_ff @(posedge clock) begin
      if (!clear) begin
         hi  <= '0;
         lo  <= '0;
         pc  <= '0;
         mdr <= '0;
         y   <= '0;
         z   <= '0;
      end else begin
         if (HiIn)  hi  <= bus;
         if (LoIn)  lo  <= bus;
         if (PCIn)  pc  <= bus;
         if (YIn)   y   <= bus;
         if (MDRIn) mdr <= MDRread ? Mdata : bus;
         if (ZIn)   z   <= alu;
      end
   end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed vectors against hand-computed values; registers are
// observed by driving them onto the bus.
module tb_data_path;

   logic        clock = 1'b0;
   logic        clear;
   logic [15:0] regIn, regOut;
   logic        HiIn, LoIn, ZIn, PCIn, MDRIn, YIn;
   logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut;
   logic [31:0] Mdata, temp;
   logic        MDRread, tempEnable;
   logic [4:0]  ALUcode;
   logic [31:0] BusMuxOut;

   int n_vec = 0;
   int n_err = 0;

   data_path dut (
      .clock(clock), .clear(clear), .regIn(regIn),
      .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .YIn(YIn),
      .regOut(regOut), .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut),
      .ZLoOut(ZLoOut), .PCOut(PCOut), .MDROut(MDROut),
      .Mdata(Mdata), .MDRread(MDRread), .ALUcode(ALUcode),
      .temp(temp), .tempEnable(tempEnable), .BusMuxOut(BusMuxOut)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      regIn = '0; regOut = '0;
      HiIn = 0; LoIn = 0; ZIn = 0; PCIn = 0; MDRIn = 0; YIn = 0;
      HiOut = 0; LoOut = 0; ZHiOut = 0; ZLoOut = 0; PCOut = 0; MDROut = 0;
      MDRread = 0; tempEnable = 0; ALUcode = '0; Mdata = '0; temp = '0;
   endtask

   // one rising edge, then return controls to idle away from the edge
   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic inject(input logic [31:0] v);
      temp = v; tempEnable = 1;
   endtask

   // load Y from temp, then run op with bus = temp and capture into Z
   task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      inject(a); YIn = 1; tick();
      inject(b); ALUcode = op; ZIn = 1; tick();
   endtask

   task automatic chk_z(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
      ZLoOut = 1; #1; chk({tag, ".lo"}, BusMuxOut, elo); ZLoOut = 0;
      ZHiOut = 1; #1; chk({tag, ".hi"}, BusMuxOut, ehi); ZHiOut = 0;
   endtask

   initial begin
      idle();
      clear = 1;
      @(negedge clock);
      // fill everything with non-zero so reset has something to clear
      inject(32'h1234_5678); regIn = '1; HiIn = 1; LoIn = 1; PCIn = 1; MDRIn = 1; YIn = 1; tick();
      inject(32'h0000_0001); ALUcode = 5'b00011; ZIn = 1; tick();
      // reset with all load strobes asserted must still clear
      clear = 0; inject(32'hDEAD_BEEF); regIn = '1; HiIn = 1; LoIn = 1; PCIn = 1; MDRIn = 1; YIn = 1; ZIn = 1;
      ALUcode = 5'b00011;
      tick();
      clear = 1;
      #1 chk("bus_idle", BusMuxOut, 32'h0);
      for (int i = 0; i < 16; i++) begin
         regOut = 16'h1 << i; #1;
         chk($sformatf("rst_r%0d", i), BusMuxOut, 32'h0);
      end
      regOut = '0;
      HiOut = 1; #1 chk("rst_hi", BusMuxOut, 32'h0); HiOut = 0;
      LoOut = 1; #1 chk("rst_lo", BusMuxOut, 32'h0); LoOut = 0;
      PCOut = 1; #1 chk("rst_pc", BusMuxOut, 32'h0); PCOut = 0;
      MDROut = 1; #1 chk("rst_mdr", BusMuxOut, 32'h0); MDROut = 0;
      chk_z("rst_z", 32'h0, 32'h0);
      // Y cleared: Y + 5 = 5
      inject(32'd5); ALUcode = 5'b00011; ZIn = 1; tick();
      chk_z("rst_y", 32'h0, 32'd5);

      // inject and NOT
      inject(32'hA); regIn[0] = 1; tick();
      regOut[0] = 1; #1 chk("r0", BusMuxOut, 32'hA);
      ALUcode = 5'b10010; ZIn = 1; tick();
      chk_z("not", 32'h0, 32'hFFFF_FFF5);
      ZLoOut = 1; regIn[5] = 1; tick();
      regOut[5] = 1; #1 chk("r5", BusMuxOut, 32'hFFFF_FFF5); regOut = '0;

      // MDR from memory and from bus
      Mdata = 32'h9280_0000; MDRread = 1; MDRIn = 1; inject(32'h1111_1111); tick();
      MDROut = 1; #1 chk("mdr_mem", BusMuxOut, 32'h9280_0000); MDROut = 0;
      Mdata = 32'h9280_0000; MDRread = 0; MDRIn = 1; inject(32'h0BAD_F00D); tick();
      MDROut = 1; #1 chk("mdr_bus", BusMuxOut, 32'h0BAD_F00D); MDROut = 0;

      // add / sub through R1, R2
      inject(32'd5); regIn[1] = 1; tick();
      inject(32'd7); regIn[2] = 1; tick();
      regOut[1] = 1; YIn = 1; tick();
      regOut[2] = 1; ALUcode = 5'b00011; ZIn = 1; tick();
      chk_z("add", 32'h0, 32'd12);
      regOut[2] = 1; ALUcode = 5'b00100; ZIn = 1; tick();
      chk_z("sub", 32'h0, 32'hFFFF_FFFE);

      // same register read and written in one cycle keeps the old value
      regOut[2] = 1; regIn[2] = 1; regIn[4] = 1; tick();
      regOut[4] = 1; #1 chk("rw_r4", BusMuxOut, 32'd7); regOut = '0;
      regOut[2] = 1; #1 chk("rw_r2", BusMuxOut, 32'd7); regOut = '0;

      // mul / div
      alu_op(32'hFFFF_FFFE, 32'd3, 5'b10000); chk_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      alu_op(32'd7, 32'd2, 5'b01111);         chk_z("div", 32'd1, 32'd3);
      alu_op(32'hFFFF_FFF9, 32'd2, 5'b01111); chk_z("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      alu_op(32'd7, 32'd0, 5'b01111);         chk_z("div0", 32'd7, 32'hFFFF_FFFF);

      // logic, neg, undefined code
      alu_op(32'h0000_F0F0, 32'h0000_FF00, 5'b00101); chk_z("and", 32'h0, 32'h0000_F000);
      alu_op(32'h0000_F0F0, 32'h0000_FF00, 5'b00110); chk_z("or", 32'h0, 32'h0000_FFF0);
      alu_op(32'd0, 32'd5, 5'b10001);                 chk_z("neg", 32'h0, 32'hFFFF_FFFB);
      alu_op(32'd9, 32'd9, 5'b11111);                 chk_z("undef", 32'h0, 32'h0);

      // shifts with Y = 0x80000001, amount 1
      alu_op(32'h8000_0001, 32'd1, 5'b00111); chk_z("ror", 32'h0, 32'hC000_0000);
      alu_op(32'h8000_0001, 32'd1, 5'b01010); chk_z("shra", 32'h0, 32'hC000_0000);
      alu_op(32'h8000_0001, 32'd1, 5'b01001); chk_z("shr", 32'h0, 32'h4000_0000);
      alu_op(32'h8000_0001, 32'd1, 5'b01000); chk_z("rol", 32'h0, 32'h0000_0003);
      alu_op(32'h8000_0001, 32'd1, 5'b01011); chk_z("shl", 32'h0, 32'h0000_0002);
      alu_op(32'h8000_0001, 32'd0, 5'b00111); chk_z("ror0", 32'h0, 32'h8000_0001);

      // bus priority
      inject(32'h33); regIn[3] = 1; tick();
      inject(32'h77); regIn[7] = 1; tick();
      inject(32'h111); HiIn = 1; tick();
      inject(32'h222); LoIn = 1; tick();
      inject(32'h99); regOut[3] = 1; #1 chk("pri_temp", BusMuxOut, 32'h99); idle();
      regOut = 16'h0088; #1 chk("pri_low_idx", BusMuxOut, 32'h33); idle();
      regOut[7] = 1; HiOut = 1; #1 chk("pri_reg_hi", BusMuxOut, 32'h77); idle();
      HiOut = 1; LoOut = 1; #1 chk("pri_hi_lo", BusMuxOut, 32'h111); idle();
      LoOut = 1; MDROut = 1; #1 chk("pri_lo_mdr", BusMuxOut, 32'h222); idle();
      inject(32'h4444); PCIn = 1; tick();
      PCOut = 1; MDROut = 1; #1 chk("pri_pc_mdr", BusMuxOut, 32'h4444); idle();

      // reset during a transfer discards it
      inject(32'h55); regIn[9] = 1; clear = 0; tick();
      clear = 1;
      regOut[9] = 1; #1 chk("rst_mid", BusMuxOut, 32'h0); idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_path.md
# data_path

32-bit register-transfer datapath for the phase-1 RISC CPU: sixteen general-purpose registers, HI/LO, PC, MDR, Y and a 64-bit Z result register share one 32-bit bus, with a 5-bit-coded ALU between Y/bus and Z. All control is supplied externally, one strobe per register, by the testbench or, later, the control unit. A debug bus-observation output exposes the bus value for verification.

## Interface
- No parameters.
- `clock`  in  1  rising-edge clock for all registers
- `clear`  in  1  synchronous active-low reset
- `regIn`  in  16  load strobes; bit i loads Ri from the bus
- `HiIn`, `LoIn`, `ZIn`, `PCIn`, `MDRIn`, `YIn`  in  1 each  register load strobes
- `regOut`  in  16  bus drive selects; bit i drives Ri
- `HiOut`, `LoOut`, `ZHiOut`, `ZLoOut`, `PCOut`, `MDROut`  in  1 each  bus drive selects
- `Mdata`  in  32  memory read data
- `MDRread`  in  1  MDR input mux: 1 selects `Mdata`, 0 selects the bus
- `ALUcode`  in  5  ALU operation
- `temp`  in  32  external bus-injection value
- `tempEnable`  in  1  drive `temp` onto the bus
- `BusMuxOut`  out  32  current bus value, combinational

## Operation
- Bus source priority, highest first: `tempEnable`, then `regOut[0..15]` with the lowest index winning, then HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut.
- With no source selected, the bus is 0.
- Register loads:
  - Ri, HI, LO, PC and Y load the bus when their strobe is 1.
  - MDR loads `MDRread ? Mdata : bus` when MDRIn is 1.
  - Z loads the 64-bit ALU result when ZIn is 1.
- R0 is an ordinary register.
- ALU operands: A = Y, B = bus. Unary operations use B. Results are 64-bit; single-word results are zero-extended into ZHi.

ALU operations by `ALUcode`:
- 00011 add A+B
- 00100 sub A−B
- 00101 and
- 00110 or
- 00111 ror A by B[4:0]
- 01000 rol A by B[4:0]
- 01001 shr A by B[4:0] (logical)
- 01010 shra A by B[4:0] (arithmetic)
- 01011 shl A by B[4:0]
- 01111 div, signed: ZLo = quotient, ZHi = remainder (sign of A).
  - Divide by zero: ZLo = 0xFFFFFFFF, ZHi = A.
- 10000 mul, signed 32×32 → 64.
- 10001 neg: −B two's complement.
- 10010 not: ~B.
- All other codes: result 0.

## Timing
- All registers update on the rising edge of `clock`.
- Reset: when `clear` = 0 at a rising edge, every register (R0–R15, HI, LO, Z, PC, MDR, Y) goes to 0, overriding all load strobes.
- Reset in the middle of a transfer discards that transfer.
- Bus, ALU result and `BusMuxOut` are combinational, so a register-to-register transfer takes 1 cycle.
- ALU operation: operands are available in the cycle ZIn is asserted, and Z holds the result after that edge.
- Simultaneous read and write of the same register in one cycle: the bus carries the old value and the register captures it.
- Control inputs change away from the rising edge and must be stable at it.

## Test plan
- Reset: hold `clear` = 0 for one edge -> all registers 0 and `BusMuxOut` = 0 with no selects asserted.
- Inject and NOT: `temp` = 0xA, tempEnable = 1, regIn[0] = 1 for one edge, so R0 = 0xA. Then regOut[0] = 1, ALUcode = 10010, ZIn = 1, so ZLo = 0xFFFFFFF5. Then ZLoOut = 1, regIn[5] = 1, so R5 = 0xFFFFFFF5.
- MDR read: `Mdata` = 0x92800000, MDRread = 1, MDRIn = 1 -> MDR = 0x92800000. Then MDROut = 1 -> `BusMuxOut` = 0x92800000.
- Add and sub: Y = 5 from R1, bus = R2 = 7.
  - ALUcode 00011 -> ZLo = 12, ZHi = 0.
  - ALUcode 00100 -> ZLo = 0xFFFFFFFE.
- Mul and div:
  - Y = 0xFFFFFFFE (−2), bus = 3: mul -> Z = 0xFFFFFFFF_FFFFFFFA.
  - Y = 7, bus = 2: div -> ZLo = 3, ZHi = 1.
  - Divide by zero -> ZLo = 0xFFFFFFFF, ZHi = 7.
- Priority and shifts:
  - tempEnable with regOut[3] -> bus = `temp`.
  - Y = 0x80000001, bus = 1:
    - ror -> 0xC0000000
    - shra -> 0xC0000000
    - shr -> 0x40000000
